edge_threshold_stats: RTL and testbench

// Downstream of the Sobel edge stage; consumes its 12-bit magnitude RGB stream.

---
 rtl/edge_threshold_stats.sv | 215 +++++++++++++++++++++
 tb/tb_edge_threshold_stats.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_threshold_stats.sv
// edge_threshold_stats
//   Post-processing stage behind the Sobel edge filter. It binarizes the edge
//   magnitude against a per-frame threshold, with hysteresis along the line.
//   It re-formats pixels for display according to a per-frame mode. It counts
//   edge pixels in each frame for software and LEDs. The pixel path is a
//   2-cycle pipeline.
//
// Ports
//   iCLK, iRST               pixel clock, asynchronous active-high reset
//   iRed/iGreen/iBlue        input channels (edge magnitude), DATA_W bits
//   iDVAL                    input pixel valid
//   iSOL                     first pixel of a line, qualified by iDVAL
//   iFVAL                    frame valid, high for the whole frame
//   iThresh, iMode           threshold and display mode, latched at frame start
//   oRed/oGreen/oBlue        formatted output channels
//   oDVAL                    output valid, iDVAL delayed by 2 cycles
//   oEdgeCount               edge count of the last completed frame
//   oCountValid              1-cycle pulse when oEdgeCount updates
//   oFrameCnt                completed-frame counter, wraps

module edge_threshold_stats #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned COUNT_W = 22,
    parameter int unsigned HYST_EN = 1
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [DATA_W-1:0]  iRed,
    input  logic [DATA_W-1:0]  iGreen,
    input  logic [DATA_W-1:0]  iBlue,
    input  logic               iDVAL,
    input  logic               iSOL,
    input  logic               iFVAL,
    input  logic [DATA_W-1:0]  iThresh,
    input  logic [1:0]         iMode,
    output logic [DATA_W-1:0]  oRed,
    output logic [DATA_W-1:0]  oGreen,
    output logic [DATA_W-1:0]  oBlue,
    output logic               oDVAL,
    output logic [COUNT_W-1:0] oEdgeCount,
    output logic               oCountValid,
    output logic [15:0]        oFrameCnt
);

    localparam logic [DATA_W-1:0]  PIX_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic               HYST_ON = (HYST_EN != 0);

    typedef enum logic [2:0] {SYNC, IDLE, FRAME, DRAIN, DONE} state_t;

    // ------------------------------------------------------------------
    // Stage 1: channel maximum and input delay
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] in_max;
    logic [DATA_W-1:0] s1_red, s1_green, s1_blue, s1_max;
    logic              s1_dval, s1_sol;

    always_comb begin
        in_max = iRed;
        if (iGreen > in_max) in_max = iGreen;
        if (iBlue > in_max)  in_max = iBlue;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_red   <= '0;
            s1_green <= '0;
            s1_blue  <= '0;
            s1_max   <= '0;
            s1_dval  <= 1'b0;
            s1_sol   <= 1'b0;
        end else begin
            s1_red   <= iRed;
            s1_green <= iGreen;
            s1_blue  <= iBlue;
            s1_max   <= in_max;
            s1_dval  <= iDVAL;
            s1_sol   <= iSOL & iDVAL;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: edge decision and output formatting
    // ------------------------------------------------------------------
    state_t            state;
    logic [DATA_W-1:0] thr_q;
    logic [1:0]        mode_q;
    logic              prev_q;
    logic              prev_eff;
    logic              edge_hit;
    logic [DATA_W-1:0] fmt_red, fmt_green, fmt_blue;

    // Hysteresis never reaches across a line start.
    assign prev_eff = prev_q & ~s1_sol;
    assign edge_hit = (s1_max >= thr_q) | (HYST_ON & prev_eff & (s1_max >= (thr_q >> 1)));

    always_comb begin
        fmt_red   = s1_red;
        fmt_green = s1_green;
        fmt_blue  = s1_blue;
        case (mode_q)
            2'b01: begin
                fmt_red   = edge_hit ? PIX_MAX : '0;
                fmt_green = edge_hit ? PIX_MAX : '0;
                fmt_blue  = edge_hit ? PIX_MAX : '0;
            end
            2'b10: begin
                fmt_red   = edge_hit ? s1_red   : '0;
                fmt_green = edge_hit ? s1_green : '0;
                fmt_blue  = edge_hit ? s1_blue  : '0;
            end
            2'b11: begin
                if (edge_hit) begin
                    fmt_red   = s1_max;
                    fmt_green = '0;
                    fmt_blue  = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs and hysteresis state only move on valid pixels.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
            oDVAL  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            oDVAL <= s1_dval;
            if (s1_dval) begin
                oRed   <= fmt_red;
                oGreen <= fmt_green;
                oBlue  <= fmt_blue;
                prev_q <= edge_hit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and edge statistics
    // ------------------------------------------------------------------
    logic               fval_q;
    logic               drain_q;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_next;

    // Count the pixel leaving stage 2 this cycle; saturate instead of wrapping.
    always_comb begin
        cnt_next = cnt_q;
        if ((state == FRAME || state == DRAIN) && s1_dval && edge_hit && cnt_q != CNT_MAX) begin
            cnt_next = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= SYNC;
            fval_q      <= 1'b0;
            drain_q     <= 1'b0;
            cnt_q       <= '0;
            thr_q       <= '0;
            mode_q      <= 2'b00;
            oEdgeCount  <= '0;
            oCountValid <= 1'b0;
            oFrameCnt   <= '0;
        end else begin
            fval_q      <= iFVAL;
            oCountValid <= 1'b0;
            case (state)
                // Skip whatever frame was in progress when reset released.
                SYNC: begin
                    if (!iFVAL) state <= IDLE;
                end
                // Only a true rising edge starts a frame, so a rise that
                // happened during DRAIN/DONE is ignored until the next one.
                IDLE: begin
                    if (iFVAL && !fval_q) begin
                        state  <= FRAME;
                        thr_q  <= iThresh;
                        mode_q <= iMode;
                        cnt_q  <= '0;
                    end
                end
                FRAME: begin
                    cnt_q <= cnt_next;
                    if (!iFVAL) begin
                        state   <= DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                // Two cycles let the last pixels clear the pipeline.
                DRAIN: begin
                    cnt_q <= cnt_next;
                    if (drain_q) begin
                        state       <= DONE;
                        oEdgeCount  <= cnt_next;
                        oCountValid <= 1'b1;
                        oFrameCnt   <= oFrameCnt + 16'd1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_threshold_stats.sv
module tb_edge_threshold_stats;

    localparam int  DW   = 12;
    localparam bit  HYST = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] iRed, iGreen, iBlue, iThresh;
    logic          iDVAL, iSOL, iFVAL;
    logic [1:0]    iMode;

    logic [DW-1:0] oRed, oGreen, oBlue;
    logic          oDVAL, oCountValid;
    logic [21:0]   oEdgeCount;
    logic [15:0]   oFrameCnt;

    logic [DW-1:0] s_red, s_green, s_blue;
    logic          s_dval, s_cv;
    logic [3:0]    s_count;
    logic [15:0]   s_frames;

    always #5 clk = ~clk;

    edge_threshold_stats u_dut (
        .iCLK(clk), .iRST(rst), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iDVAL(iDVAL), .iSOL(iSOL), .iFVAL(iFVAL), .iThresh(iThresh), .iMode(iMode),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL),
        .oEdgeCount(oEdgeCount), .oCountValid(oCountValid), .oFrameCnt(oFrameCnt)
    );

    // Narrow counter instance to observe saturation.
    edge_threshold_stats #(.COUNT_W(4)) u_sat (
        .iCLK(clk), .iRST(rst), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iDVAL(iDVAL), .iSOL(iSOL), .iFVAL(iFVAL), .iThresh(iThresh), .iMode(iMode),
        .oRed(s_red), .oGreen(s_green), .oBlue(s_blue), .oDVAL(s_dval),
        .oEdgeCount(s_count), .oCountValid(s_cv), .oFrameCnt(s_frames)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] r, g, b;
    } pix_t;
    typedef struct {
        int unsigned due;
        int unsigned cnt;
        int unsigned frames;
    } cnt_t;

    pix_t pq[$];
    cnt_t cq[$];

    // Reference model state
    int unsigned m_thr      = 0;
    logic [1:0]  m_mode     = 2'b00;
    bit          m_prev     = 1'b0;
    bit          m_counting = 1'b0;
    int unsigned m_cnt      = 0;
    int unsigned m_frames   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Drive one valid pixel and queue its expected output.
    task automatic pix(input int unsigned r, input int unsigned g, input int unsigned b,
                       input bit sol);
        int unsigned m;
        bit          e;
        pix_t        p;
        m = r;
        if (g > m) m = g;
        if (b > m) m = b;
        e = (m >= m_thr) || (HYST && m_prev && !sol && (m >= m_thr / 2));
        m_prev = e;
        if (m_counting && e) m_cnt++;
        p.r = DW'(r); p.g = DW'(g); p.b = DW'(b);
        case (m_mode)
            2'b01: begin p.r = e ? 12'hFFF : 12'h0; p.g = p.r; p.b = p.r; end
            2'b10: if (!e) begin p.r = 0; p.g = 0; p.b = 0; end
            2'b11: if (e) begin p.r = DW'(m); p.g = 0; p.b = 0; end
            default: ;
        endcase
        p.due = cyc + 2;
        pq.push_back(p);
        iRed = DW'(r); iGreen = DW'(g); iBlue = DW'(b);
        iSOL = sol; iDVAL = 1'b1;
        @(posedge clk); #1;
    endtask

    // Invalid cycles carry junk data and SOL, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            iDVAL = 1'b0;
            iSOL = 1'($urandom);
            iRed = DW'($urandom); iGreen = DW'($urandom); iBlue = DW'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic frame_begin(input int unsigned thr, input logic [1:0] mode);
        iThresh = DW'(thr); iMode = mode; iFVAL = 1'b1;
        m_thr = thr; m_mode = mode; m_counting = 1'b1; m_cnt = 0;
    endtask

    task automatic frame_fall();
        cnt_t c;
        iDVAL = 1'b0; iFVAL = 1'b0;
        m_frames++;
        c.due = cyc + 3; c.cnt = m_cnt; c.frames = m_frames;
        cq.push_back(c);
        m_counting = 1'b0;
    endtask

    task automatic frame_end();
        frame_fall();
        idle(8);
    endtask

    task automatic rand_rows(input int w, input int h);
        int unsigned vmax;
        vmax = m_thr * 3 / 2 + 1;
        if (vmax > 4095) vmax = 4095;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                pix($urandom_range(0, vmax), $urandom_range(0, vmax),
                    $urandom_range(0, vmax), x == 0);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            // Threshold changes mid-frame must not take effect.
            if (y == 0) iThresh = DW'($urandom);
            idle(2);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    logic [DW-1:0] last_r = '0, last_g = '0, last_b = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pix_t p;
                p = pq.pop_front();
                check("odval_latency", oDVAL, 1);
                check("out_red", oRed, p.r);
                check("out_green", oGreen, p.g);
                check("out_blue", oBlue, p.b);
                last_r = p.r; last_g = p.g; last_b = p.b;
            end else begin
                check("odval_idle", oDVAL, 0);
                check("hold_red", oRed, last_r);
                check("hold_green", oGreen, last_g);
                check("hold_blue", oBlue, last_b);
            end
            if (cq.size() > 0 && cq[0].due == cyc) begin
                cnt_t c;
                c = cq.pop_front();
                check("count_valid", oCountValid, 1);
                check("edge_count", oEdgeCount, c.cnt);
                check("edge_count_sat", s_count, (c.cnt > 15) ? 15 : c.cnt);
                check("sat_count_valid", s_cv, 1);
                check("frame_cnt", oFrameCnt, c.frames);
            end else begin
                check("count_valid_idle", oCountValid, 0);
                check("sat_count_valid_idle", s_cv, 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; iFVAL = 1'b1; iDVAL = 1'b0; iSOL = 1'b0;
        iRed = '0; iGreen = '0; iBlue = '0; iThresh = '0; iMode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_odval", oDVAL, 0);
        check("rst_red", oRed, 0);
        check("rst_count", oEdgeCount, 0);
        check("rst_count_valid", oCountValid, 0);
        check("rst_frame_cnt", oFrameCnt, 0);
        rst = 1'b0;

        // Released mid-frame: processed with reset shadows, never counted.
        for (int i = 0; i < 100; i++) pix(4095, 4095, 4095, (i % 10) == 0);
        iFVAL = 1'b0;
        idle(4);
        frame_begin(1500, 2'b10);
        rand_rows(6, 3);
        frame_end();

        // Single pixel latency and mode 01.
        frame_begin(200, 2'b01);
        pix(10, 300, 20, 1'b1);
        frame_end();

        // Hysteresis along a line and its reset at SOL.
        frame_begin(100, 2'b01);
        pix(50, 50, 50, 1'b1);
        pix(120, 120, 120, 1'b0);
        pix(60, 60, 60, 1'b0);
        pix(60, 60, 60, 1'b0);
        pix(40, 40, 40, 1'b0);
        pix(60, 60, 60, 1'b0);
        idle(2);
        pix(120, 120, 120, 1'b1);
        pix(60, 60, 60, 1'b1);
        frame_end();

        // 8x4 frame with exactly 13 edges.
        frame_begin(1000, 2'b10);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (((y * 8 + x) * 5) % 32 < 13)
                    pix($urandom_range(1000, 4095), $urandom_range(0, 499), 7, x == 0);
                else
                    pix($urandom_range(0, 499), $urandom_range(0, 499), 3, x == 0);
            end
            idle(1);
        end
        frame_end();

        // 20 edges: saturates the narrow counter; threshold change is ignored.
        frame_begin(500, 2'b01);
        for (int i = 0; i < 20; i++) begin
            pix(4000, 10, 10, i == 0);
            if (i == 9) iThresh = 12'hFFF;
        end
        frame_end();

        // Mode 11 with and without an edge.
        frame_begin(80, 2'b11);
        pix(50, 80, 30, 1'b1);
        frame_end();
        frame_begin(81, 2'b11);
        pix(50, 80, 30, 1'b1);
        pix(60, 40, 70, 1'b1);
        frame_end();

        // iFVAL rises again during DRAIN: that frame is missed.
        frame_begin(900, 2'b01);
        rand_rows(5, 2);
        frame_fall();
        @(posedge clk); #1;
        iFVAL = 1'b1;
        idle(6);
        for (int i = 0; i < 6; i++) pix($urandom_range(0, 2000), 5, 5, i == 0);
        iFVAL = 1'b0;
        idle(6);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            frame_begin($urandom_range(100, 3800), 2'($urandom));
            rand_rows($urandom_range(3, 10), $urandom_range(2, 5));
            frame_end();
        end

        idle(10);
        check("pix_queue_drained", pq.size(), 0);
        check("count_queue_drained", cq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
